// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, default bus widths and the
// instruction buffer entry layout.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W = 32;
    localparam int unsigned CPU_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [CPU_ADDR_W-1:0] pc;
        logic [CPU_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch unit bundle: PC handshake, instruction memory request/response, flush
// and decode-side buffer head. The slave modport is the fetch unit's view.
interface instruction_fetch_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
);
    logic [ADDR_W-1:0] PCInput;
    logic              PCValid;
    logic              PCReady;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemReqValid;
    logic              MemReqReady;
    logic              MemRspValid;
    logic [DATA_W-1:0] MemRspData;
    logic              Flush;
    logic [DATA_W-1:0] Instr;
    logic [ADDR_W-1:0] InstrPC;
    logic              InstrValid;
    logic              InstrReady;

    modport slave (
        input  PCInput, PCValid, MemReqReady, MemRspValid, MemRspData, Flush, InstrReady,
        output PCReady, MemAddr, MemReqValid, Instr, InstrPC, InstrValid
    );

    modport master (
        output PCInput, PCValid, MemReqReady, MemRspValid, MemRspData, Flush, InstrReady,
        input  PCReady, MemAddr, MemReqValid, Instr, InstrPC, InstrValid
    );

endinterface

// File: rtl/instr_fifo.sv
// DEPTH-entry synchronous instruction buffer holding {pc, instr} pairs.
// Clear wins over a same-cycle push or pop.
module instr_fifo
    import cpu_pkg::*;
#(
    parameter  int ADDR_W = CPU_ADDR_W,
    parameter  int DATA_W = CPU_DATA_W,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [DATA_W-1:0] push_instr_i,
    input  logic              pop_i,
    input  logic              clear_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [DATA_W-1:0] head_instr_o
);

    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                pc_mem_q[wr_ptr_q]    <= push_pc_i;
                instr_mem_q[wr_ptr_q] <= push_instr_i;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o      = count_q;
    assign head_pc_o    = pc_mem_q[rd_ptr_q];
    assign head_instr_o = instr_mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit feeding decode through instr_fifo.
// Optional IFETCH_STALLCNT_EN adds a saturating decode-starvation counter.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    instruction_fetch_if.slave  bus
`ifdef IFETCH_STALLCNT_EN
    ,
    output logic [15:0]         StallCount
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic              drop_q, drop_d;

    logic [CNT_W-1:0]  count_s;
    logic [ADDR_W-1:0] head_pc_s;
    logic [DATA_W-1:0] head_instr_s;
    logic              pc_ready_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              instr_valid_s;

    assign pc_ready_s    = (state_q == IDLE) && (count_s < DEPTH_C) && !bus.Flush;
    assign accept_s      = bus.PCValid && pc_ready_s;
    assign instr_valid_s = (count_s != '0);
    assign pop_s         = instr_valid_s && bus.InstrReady;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pc_q    <= '0;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
        end
    end

    // drop_q remembers a flush seen while the request is still waiting for grant.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        req_d   = req_q;
        drop_d  = drop_q;
        push_s  = 1'b0;
        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (accept_s) begin
                    addr_d  = {bus.PCInput[ADDR_W-1:2], 2'b00};
                    pc_d    = bus.PCInput;
                    req_d   = 1'b1;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus.MemReqReady) begin
                    req_d   = 1'b0;
                    drop_d  = 1'b0;
                    state_d = (drop_q || bus.Flush) ? DROP : WAIT;
                end else begin
                    drop_d  = drop_q || bus.Flush;
                end
            end
            WAIT: begin
                if (bus.MemRspValid) begin
                    push_s  = 1'b1;
                    state_d = IDLE;
                end else if (bus.Flush) begin
                    state_d = DROP;
                end else begin
                    state_d = WAIT;
                end
            end
            DROP: begin
                if (bus.MemRspValid) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                drop_d  = 1'b0;
            end
        endcase
    end

    instr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .Clk          (Clk),
        .Reset        (Reset),
        .push_i       (push_s),
        .push_pc_i    (pc_q),
        .push_instr_i (bus.MemRspData),
        .pop_i        (pop_s),
        .clear_i      (bus.Flush),
        .count_o      (count_s),
        .head_pc_o    (head_pc_s),
        .head_instr_o (head_instr_s)
    );

    assign bus.PCReady     = pc_ready_s;
    assign bus.MemAddr     = addr_q;
    assign bus.MemReqValid = req_q;
    assign bus.Instr       = head_instr_s;
    assign bus.InstrPC     = head_pc_s;
    assign bus.InstrValid  = instr_valid_s;

`ifdef IFETCH_STALLCNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.InstrReady && !instr_valid_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Cleared by Reset only; a flush leaves the statistic intact.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed fetches with hand-computed
// words, a behavioural memory, and a monitor checking every decode pop.
module tb_instruction_fetch;
    import cpu_pkg::*;

    logic Clk;
    logic Reset;

    instruction_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef IFETCH_STALLCNT_EN
    logic [15:0] StallCount;
`endif

    instruction_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
`ifdef IFETCH_STALLCNT_EN
        ,
        .StallCount (StallCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int vectors     = 0;
    int miscompares = 0;
    int rsp_delay   = 1;
    int grant_cnt   = 0;
    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h1111_0000;
            32'h0000_0004: return 32'hDEAD_BEEF;
            32'h0000_0008: return 32'h8888_8888;
            32'h0000_0100: return 32'hCAFE_0100;
            default:       return a ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] w);
        int n;
        n = 0;
        bus.PCInput = a;
        bus.PCValid = 1'b1;
        forever begin
            @(negedge Clk);
            if (bus.PCReady) break;
            n++;
            if (n > 50) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: PCReady stayed %b, expected 1", bus.PCReady);
                break;
            end
        end
        exp_q.push_back('{pc: a, instr: w});
        @(posedge Clk);
        #1;
        bus.PCValid = 1'b0;
    endtask

    // Memory model: one response rsp_delay cycles after each grant.
    initial begin : memory_model
        int cd;
        logic g;
        logic [31:0] a;
        logic [31:0] pend;
        cd = 0;
        pend = 32'h0;
        bus.MemRspValid = 1'b0;
        bus.MemRspData  = 32'h0;
        forever begin
            @(posedge Clk);
            g = bus.MemReqValid && bus.MemReqReady && !Reset;
            a = bus.MemAddr;
            #1;
            bus.MemRspValid = 1'b0;
            if (Reset) begin
                cd = 0;
            end else begin
                if (g) begin
                    grant_cnt++;
                    pend = a;
                    cd = rsp_delay;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        bus.MemRspValid = 1'b1;
                        bus.MemRspData  = mem_word(pend);
                    end
                end
            end
        end
    end

    // Monitor: every decode pop must match the oldest expected entry.
    always @(negedge Clk) begin
        if (!Reset && bus.InstrValid && bus.InstrReady) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_instr: got pc %h instr %h, expected no output",
                         bus.InstrPC, bus.Instr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("instr", 64'(bus.Instr), 64'(mon_e.instr));
                chk("instr_pc", 64'(bus.InstrPC), 64'(mon_e.pc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        int g0;
        Reset           = 1'b1;
        bus.PCInput     = 32'h0;
        bus.PCValid     = 1'b0;
        bus.MemReqReady = 1'b1;
        bus.Flush       = 1'b0;
        bus.InstrReady  = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Reset state
        @(negedge Clk);
        chk("rst_pcready", 64'(bus.PCReady), 64'd1);
        chk("rst_memreqvalid", 64'(bus.MemReqValid), 64'd0);
        chk("rst_memaddr", 64'(bus.MemAddr), 64'd0);
        chk("rst_instrvalid", 64'(bus.InstrValid), 64'd0);
        chk("rst_instr", 64'(bus.Instr), 64'd0);
        chk("rst_instrpc", 64'(bus.InstrPC), 64'd0);
        tick();

        // Basic fetch and 3-cycle latency
        bus.InstrReady = 1'b1;
        fetch(32'h0000_0004, 32'hDEAD_BEEF);
        @(negedge Clk);
        chk("basic_reqvalid", 64'(bus.MemReqValid), 64'd1);
        chk("basic_memaddr", 64'(bus.MemAddr), 64'h4);
        @(negedge Clk);
        chk("basic_n2_instrvalid", 64'(bus.InstrValid), 64'd0);
        @(negedge Clk);
        chk("basic_n3_instrvalid", 64'(bus.InstrValid), 64'd1);
        tick();
        tick();

        // Backpressure fill
        bus.InstrReady = 1'b0;
        fetch(32'h0000_0000, 32'h1111_0000);
        fetch(32'h0000_0004, 32'hDEAD_BEEF);
        repeat (4) tick();
        @(negedge Clk);
        chk("full_pcready", 64'(bus.PCReady), 64'd0);
        chk("full_instrvalid", 64'(bus.InstrValid), 64'd1);
        tick();
        bus.InstrReady = 1'b1;
        tick();
        bus.InstrReady = 1'b0;
        @(negedge Clk);
        chk("after_pop_pcready", 64'(bus.PCReady), 64'd1);
        tick();
        bus.InstrReady = 1'b1;
        repeat (2) tick();

        // Grant stall
        g0 = grant_cnt;
        bus.MemReqReady = 1'b0;
        fetch(32'h0000_0010, 32'hA5A5_A5B5);
        bus.PCValid = 1'b1;
        bus.PCInput = 32'h0000_0020;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("stall_reqvalid", 64'(bus.MemReqValid), 64'd1);
            chk("stall_memaddr", 64'(bus.MemAddr), 64'h10);
            chk("stall_pcready", 64'(bus.PCReady), 64'd0);
            tick();
        end
        bus.PCValid = 1'b0;
        bus.MemReqReady = 1'b1;
        repeat (4) tick();
        @(negedge Clk);
        chk("stall_grant_count", 64'(grant_cnt - g0), 64'd1);
        tick();

        // Flush in WAIT with one buffered entry
        bus.InstrReady = 1'b0;
        fetch(32'h0000_0000, 32'h1111_0000);
        repeat (4) tick();
        rsp_delay = 4;
        fetch(32'h0000_0008, 32'h8888_8888);
        tick();
        bus.Flush = 1'b1;
        exp_q.delete();
        tick();
        bus.Flush = 1'b0;
        @(negedge Clk);
        chk("flush_instrvalid", 64'(bus.InstrValid), 64'd0);
        chk("drop_pcready", 64'(bus.PCReady), 64'd0);
        rsp_delay = 1;
        bus.InstrReady = 1'b1;
        fetch(32'h0000_0100, 32'hCAFE_0100);
        repeat (4) tick();
        bus.Flush = 1'b1;
        @(negedge Clk);
        chk("flush_idle_pcready", 64'(bus.PCReady), 64'd0);
        tick();
        bus.Flush = 1'b0;
        @(negedge Clk);
        chk("idle_pcready", 64'(bus.PCReady), 64'd1);
        tick();

        // Simultaneous push and pop at count 1
        bus.InstrReady = 1'b0;
        fetch(32'h0000_0020, 32'hA5A5_A585);
        repeat (4) tick();
        fetch(32'h0000_0024, 32'hA5A5_A581);
        tick();
        bus.InstrReady = 1'b1;
        tick();
        bus.InstrReady = 1'b0;
        @(negedge Clk);
        chk("pushpop_instrvalid", 64'(bus.InstrValid), 64'd1);
        chk("pushpop_pcready", 64'(bus.PCReady), 64'd1);
        chk("pushpop_head_pc", 64'(bus.InstrPC), 64'h24);
        chk("pushpop_head_instr", 64'(bus.Instr), 64'hA5A5_A581);
        tick();
        bus.InstrReady = 1'b1;
        repeat (2) tick();

        // Misaligned fetch address
        fetch(32'h0000_0006, 32'hDEAD_BEEF);
        @(negedge Clk);
        chk("misaligned_memaddr", 64'(bus.MemAddr), 64'h4);
        repeat (4) tick();

        // Reset mid-operation
        bus.InstrReady = 1'b0;
        fetch(32'h0000_0030, 32'hA5A5_A595);
        repeat (3) tick();
        Reset = 1'b1;
        exp_q.delete();
        @(negedge Clk);
        chk("midrst_instrvalid", 64'(bus.InstrValid), 64'd0);
        chk("midrst_memreqvalid", 64'(bus.MemReqValid), 64'd0);
        chk("midrst_memaddr", 64'(bus.MemAddr), 64'd0);
        chk("midrst_pcready", 64'(bus.PCReady), 64'd1);
        bus.InstrReady = 1'b1;
        tick();
        Reset = 1'b0;
        repeat (10) tick();
`ifdef IFETCH_STALLCNT_EN
        @(negedge Clk);
        chk("stallcount", 64'(StallCount), 64'd10);
`endif
        @(negedge Clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
